// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with private HI/LO registers.
// Shift-add multiply (LSB first) and restoring divide (MSB first), 32 iterations plus a sign-fix cycle.
module mult_div_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        mthi,
   input  logic        mtlo,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t      state, state_n;
   logic        busy_n, done_n;
   logic [4:0]  cnt;
   logic        is_div, qsign, rsign;
   logic [31:0] a_mag, b_mag;
   logic [63:0] acc;
   logic [31:0] rem;

   logic        signed_op;
   logic [31:0] a_abs, b_abs;
   logic [32:0] mul_sum, div_shift, div_trial;
   logic [63:0] prod_fix;
   logic [31:0] quot_fix, rem_fix;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         busy  <= busy_n;
         done  <= done_n;
      end
   end

   always_comb begin
      state_n = state;
      busy_n  = busy;
      done_n  = 1'b0;
      case (state)
         IDLE: if (start) begin
            state_n = CALC;
            busy_n  = 1'b1;
         end
         CALC: if (cnt == 5'd31) state_n = FIX;
         FIX: begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
         end
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      signed_op = ~op[0];
      a_abs     = (signed_op && A[31]) ? -A : A;
      b_abs     = (signed_op && B[31]) ? -B : B;
      mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, a_mag} : '0);
      div_shift = {rem, acc[31]};
      div_trial = div_shift - {1'b0, b_mag};
      prod_fix  = qsign ? -acc : acc;
      quot_fix  = qsign ? -acc[31:0] : acc[31:0];
      rem_fix   = rsign ? -rem : rem;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt    <= '0;
         is_div <= 1'b0;
         qsign  <= 1'b0;
         rsign  <= 1'b0;
         a_mag  <= '0;
         b_mag  <= '0;
         acc    <= '0;
         rem    <= '0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  is_div <= op[1];
                  qsign  <= signed_op & (A[31] ^ B[31]);
                  rsign  <= signed_op & A[31];
                  a_mag  <= a_abs;
                  b_mag  <= b_abs;
                  cnt    <= '0;
                  rem    <= '0;
                  acc    <= op[1] ? {32'd0, a_abs} : {32'd0, b_abs};
               end else begin
                  if (mthi) hi <= A;
                  if (mtlo) lo <= A;
               end
            end
            CALC: begin
               cnt <= cnt + 5'd1;
               if (is_div) begin
                  // Quotient bits shift into acc[31:0] as dividend bits shift out.
                  if (!div_trial[32]) begin
                     rem        <= div_trial[31:0];
                     acc[31:0]  <= {acc[30:0], 1'b1};
                  end else begin
                     rem        <= div_shift[31:0];
                     acc[31:0]  <= {acc[30:0], 1'b0};
                  end
               end else begin
                  acc <= {mul_sum, acc[31:1]};
               end
            end
            FIX: begin
               if (is_div) begin
                  // With B=0 the remainder ends as |A|, so the sign fix restores original A.
                  lo <= (b_mag == '0) ? '1 : quot_fix;
                  hi <= rem_fix;
               end else begin
                  hi <= prod_fix[63:32];
                  lo <= prod_fix[31:0];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: table of directed operations plus hand-written corner sequences.
module tb_mult_div_unit;

   logic        clk, reset, start, mthi, mtlo;
   logic [1:0]  op;
   logic [31:0] A, B;
   logic        busy, done;
   logic [31:0] hi, lo;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   mult_div_unit dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
      .mthi(mthi), .mtlo(mtlo), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      string       name;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Call at #1 after an edge with the unit idle; returns at #1 after the done edge.
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input string name);
      int lat;
      lat = 0;
      op = o; A = a; B = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; A = 32'h5A5A5A5A; B = 32'hA5A5A5A5; op = ~o;
      chk({name, " busy@E0"}, {31'd0, busy}, 32'd1);
      chk({name, " done@E0"}, {31'd0, done}, 32'd0);
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = i;
            break;
         end
      end
      chk({name, " latency"}, lat, 33);
      chk({name, " busy@done"}, {31'd0, busy}, 32'd0);
      chk({name, " hi"}, hi, ehi);
      chk({name, " lo"}, lo, elo);
   endtask

   initial begin
      int ndone;
      logic [31:0] hold_hi, hold_lo;

      vecs.push_back('{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, "mult_m3x5"});
      vecs.push_back('{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max"});
      vecs.push_back('{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, "mult_m1xm1"});
      vecs.push_back('{2'b00, 32'h00000007, 32'hFFFFFFF8, 32'hFFFFFFFF, 32'hFFFFFFC8, "mult_7xm8"});
      vecs.push_back('{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7d2"});
      vecs.push_back('{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC, "divu_big"});
      vecs.push_back('{2'b10, 32'h00000064, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, "div_100dm7"});
      vecs.push_back('{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_ovf"});
      vecs.push_back('{2'b11, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, "divu_by0"});
      vecs.push_back('{2'b10, 32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF, "div_by0"});

      reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; op = 2'b00; A = '0; B = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst busy", {31'd0, busy}, 32'd0);
      chk("rst done", {31'd0, done}, 32'd0);
      chk("rst hi", hi, 32'd0);
      chk("rst lo", lo, 32'd0);

      // Back-to-back: each op starts in the cycle its predecessor raises done.
      foreach (vecs[k]) run_op(vecs[k].op, vecs[k].a, vecs[k].b, vecs[k].hi, vecs[k].lo, vecs[k].name);
      @(posedge clk); #1;
      chk("done one pulse", {31'd0, done}, 32'd0);

      // Moves in IDLE
      A = 32'hCAFEF00D; mthi = 1'b1; mtlo = 1'b1;
      @(posedge clk); #1;
      mthi = 1'b0; mtlo = 1'b0;
      chk("mt both hi", hi, 32'hCAFEF00D);
      chk("mt both lo", lo, 32'hCAFEF00D);
      A = 32'h22222222; mtlo = 1'b1;
      @(posedge clk); #1;
      mtlo = 1'b0;
      chk("mtlo hi keep", hi, 32'hCAFEF00D);
      chk("mtlo lo", lo, 32'h22222222);

      // start/mthi at E5 ignored while busy; hi/lo stay stable during CALC
      op = 2'b00; A = 32'd6; B = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1 op = 2'b01; A = 32'h0000FFFF; B = 32'h00001000; start = 1'b1; mthi = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; mthi = 1'b0;
      chk("busy ign hi stable", hi, 32'hCAFEF00D);
      chk("busy ign lo stable", lo, 32'h22222222);
      ndone = 0;
      for (int i = 6; i <= 33; i++) begin
         @(posedge clk); #1;
         if (done) begin
            ndone = i;
            break;
         end
      end
      chk("busy ign latency", ndone, 33);
      chk("busy ign hi", hi, 32'd0);
      chk("busy ign lo", lo, 32'd42);
      repeat (2) @(posedge clk);
      #1 chk("busy ign no 2nd op", {31'd0, busy}, 32'd0);

      // start + mtlo: only the operation runs
      op = 2'b00; A = 32'd3; B = 32'd4; start = 1'b1; mtlo = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; mtlo = 1'b0;
      chk("start+mtlo lo kept", lo, 32'd42);
      chk("start+mtlo busy", {31'd0, busy}, 32'd1);
      ndone = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (done) begin
            ndone = i;
            break;
         end
      end
      chk("start+mtlo latency", ndone, 33);
      chk("start+mtlo lo", lo, 32'd12);

      // Reset mid-operation at E10
      @(posedge clk); #1;
      hold_hi = hi; hold_lo = lo;
      chk("pre-reset lo nonzero", lo, 32'd12);
      op = 2'b01; A = 32'hFFFFFFFF; B = 32'h00000003; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("midrst busy", {31'd0, busy}, 32'd0);
      chk("midrst done", {31'd0, done}, 32'd0);
      chk("midrst hi", hi, 32'd0);
      chk("midrst lo", lo, 32'd0);
      @(posedge clk); #1 reset = 1'b0;
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done || busy) ndone++;
      end
      chk("midrst no done", ndone, 0);
      run_op(2'b00, 32'd6, 32'd7, 32'd0, 32'd42, "mult_6x7_after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
